dff_bist_checker: RTL

Self-checking built-in test driver for a single D flip-flop (ports d, clk, q, q_b).
- Drives a pseudo-random bit stream into the flip-flop's d input.
- Samples q (and optionally q_b) one cycle later and counts mismatches.
- Reports a pass/fail verdict, so flip-flop blocks can be checked in hardware without a simulation bench.

---
 rtl/dff_bist_checker.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dff_bist_checker.sv
// dff_bist_checker: built-in test driver for a single D flip-flop.
// Drives an 8-bit LFSR bit stream into the flip-flop's d input and compares
// its q (and q_b when QB_CHECK_EN is defined) one cycle later against the
// bit that was driven. It counts mismatching cycles with saturation and
// reports a pass/fail verdict at the end of each run.
//
// Build option:
//   QB_CHECK_EN  when defined, dut_qb must equal ~expected. A cycle where
//                q, q_b or both mismatch counts as one error.
//
// Ports:
//   clk      clock, shared with the flip-flop under test (rising edge)
//   rst      asynchronous active-low reset
//   start    one-cycle pulse that begins a run; only accepted in IDLE
//   dut_q    q of the flip-flop under test
//   dut_qb   q_b of the flip-flop under test
//   dut_d    registered drive to d of the flip-flop under test
//   busy     high while in RUN or DRAIN
//   done     one-cycle pulse at the end of a run
//   pass     verdict of the last run, held until the next start
//   err_cnt  mismatch count of the last or current run (saturating)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; dut_d held at 0
// RUN   | LEN cycles: stream LFSR bits into dut_d and check returned q
// DRAIN | one cycle: dut_d back to 0, final bit checked
// DONE  | one cycle: done pulse, verdict valid
module dff_bist_checker #(
   parameter int unsigned LEN   = 16,
   parameter logic [7:0]  SEED  = 8'hA5,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             dut_q,
   input  logic             dut_qb,
   output logic             dut_d,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [15:0] LAST_CNT = 16'(LEN - 1);

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       lfsr;
   logic [15:0]      bit_cnt;
   logic             exp_bit;
   logic             valid;
   logic             last_bit;
   logic             check_en;
   logic             mismatch;
   logic [CNT_W-1:0] err_nxt;

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[7] ^ v[5] ^ v[4] ^ v[3], v[7:1]};
   endfunction

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (last_bit) state_nxt = S_DRAIN;
         S_DRAIN: state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         S_RUN,
         S_DRAIN: busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign last_bit = (bit_cnt == LAST_CNT);
   assign check_en = valid && ((state == S_RUN) || (state == S_DRAIN));

`ifdef QB_CHECK_EN
   assign mismatch = (dut_q != exp_bit) || (dut_qb != ~exp_bit);
`else
   logic unused_qb;
   assign unused_qb = dut_qb;
   assign mismatch  = (dut_q != exp_bit);
`endif

   always_comb begin
      err_nxt = err_cnt;
      if (check_en && mismatch && (err_cnt != {CNT_W{1'b1}})) begin
         err_nxt = err_cnt + CNT_W'(1);
      end
   end

   // Datapath. dut_d is registered, so the first bit is launched on the
   // accepting start edge; the LFSR is loaded one step past SEED so that
   // lfsr[0] is always the next bit to drive. The flip-flop under test then
   // captures each bit one edge later, and exp_bit (taken from dut_d)
   // lines up with the q that comes back on the following edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr    <= SEED;
         dut_d   <= 1'b0;
         pass    <= 1'b0;
         err_cnt <= '0;
         bit_cnt <= '0;
         exp_bit <= 1'b0;
         valid   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               dut_d <= 1'b0;
               if (start) begin
                  lfsr    <= lfsr_step(SEED);
                  dut_d   <= SEED[0];
                  err_cnt <= '0;
                  pass    <= 1'b0;
                  bit_cnt <= '0;
                  valid   <= 1'b0;
               end
            end
            S_RUN: begin
               err_cnt <= err_nxt;
               exp_bit <= dut_d;
               valid   <= 1'b1;
               bit_cnt <= bit_cnt + 16'd1;
               if (last_bit) begin
                  dut_d <= 1'b0;
               end else begin
                  dut_d <= lfsr[0];
                  lfsr  <= lfsr_step(lfsr);
               end
            end
            S_DRAIN: begin
               dut_d   <= 1'b0;
               err_cnt <= err_nxt;
               // Verdict includes this final check so it is valid with done.
               pass    <= (err_nxt == '0);
            end
            default: begin
               dut_d <= 1'b0;
            end
         endcase
      end
   end

endmodule
